mod_up_down_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 17 +
 rtl/tick_prescaler.sv | 41 ++++
 rtl/mod_up_down_counter.sv | 99 +++++++++
 tb/tb_mod_up_down_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo up/down counter.
package counter_pkg;

    localparam int unsigned WRAP = 0;
    localparam int unsigned SAT  = 1;

    // Smallest r with 2**r >= v; sizes the prescaler phase register.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides qualified enable cycles down to one tick every PRESCALE cycles.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_direct
            // No phase to track: every qualified enable is a tick.
            logic unused_ports;
            assign unused_ports = &{1'b0, clk, reset_n};
            assign tick = en & ~clr;
        end else begin : g_count
            localparam int unsigned PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase;

            // Phase advances on enable, holds otherwise, restarts on clr.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    phase <= '0;
                end else if (clr) begin
                    phase <= '0;
                end else if (en) begin
                    phase <= (phase == LAST) ? '0 : phase + PW'(1);
                end
            end

            assign tick = en & ~clr & (phase == LAST);
        end
    endgenerate

endmodule

// File: rtl/mod_up_down_counter.sv
// Modulo-MOD up/down counter with clear, clamped load, prescaler,
// wrap/saturate limits and a registered terminal-count pulse.
module mod_up_down_counter
    import counter_pkg::*;
#(
    parameter int unsigned BITS     = 4,
    parameter int unsigned MOD      = 16,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned PRESCALE = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] D,
    input  logic            enable,
    input  logic            up,
    output logic [BITS-1:0] Q,
    output logic            at_max,
    output logic            at_min,
    output logic            tc
);

    localparam logic [BITS-1:0] MAX = BITS'(MOD - 1);

    generate
        if (MOD < 2) begin : g_bad_mod
            $error("mod_up_down_counter: MOD must be >= 2");
        end
        if (64'(MOD) > (64'd1 << BITS)) begin : g_bad_bits
            $error("mod_up_down_counter: MOD must fit in BITS");
        end
        if (PRESCALE < 1) begin : g_bad_pre
            $error("mod_up_down_counter: PRESCALE must be >= 1");
        end
    endgenerate

    logic [BITS-1:0] q_r, q_nxt;
    logic            tc_r, tc_nxt;
    logic            step;

    // clear and load both restart the prescaler phase.
    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (clear | load),
        .en     (enable),
        .tick   (step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r  <= '0;
            tc_r <= 1'b0;
        end else begin
            q_r  <= q_nxt;
            tc_r <= tc_nxt;
        end
    end

    // Priority clear > load > step > hold; tc flags a step taken at a limit.
    always_comb begin
        q_nxt  = q_r;
        tc_nxt = 1'b0;
        if (clear) begin
            q_nxt = '0;
        end else if (load) begin
            q_nxt = (D > MAX) ? MAX : D;
        end else if (step) begin
            if (up) begin
                if (q_r == MAX) begin
                    tc_nxt = 1'b1;
                    if (SATURATE == WRAP) begin
                        q_nxt = '0;
                    end
                end else begin
                    q_nxt = q_r + BITS'(1);
                end
            end else begin
                if (q_r == '0) begin
                    tc_nxt = 1'b1;
                    if (SATURATE == WRAP) begin
                        q_nxt = MAX;
                    end
                end else begin
                    q_nxt = q_r - BITS'(1);
                end
            end
        end
    end

    assign Q      = q_r;
    assign tc     = tc_r;
    assign at_max = (q_r == MAX);
    assign at_min = (q_r == '0);

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Four counter configurations driven by shared stimulus, each checked every
// cycle against an integer reference model, plus directed literal checks.
module tb_mod_up_down_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = 4'd0;
    logic       enable = 1'b0;
    logic       up = 1'b0;

    logic [3:0] q0, q1, q2;
    logic [2:0] q3;
    logic [3:0] amax, amin, tcs;

    int n_cmp = 0;
    int n_err = 0;

    // Configurations: 0 wrap/P1, 1 saturate/P1, 2 wrap/P3, 3 (3-bit MOD5) saturate/P2.
    localparam int CM [4] = '{10, 10, 10, 5};
    localparam int CS [4] = '{0, 1, 0, 1};
    localparam int CP [4] = '{1, 1, 3, 2};

    int mq [4];
    int mp [4];
    int mtc[4];

    always #5 clk = ~clk;

    mod_up_down_counter #(.BITS(4), .MOD(10), .SATURATE(0), .PRESCALE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .D(d),
        .enable(enable), .up(up), .Q(q0), .at_max(amax[0]), .at_min(amin[0]), .tc(tcs[0]));
    mod_up_down_counter #(.BITS(4), .MOD(10), .SATURATE(1), .PRESCALE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .D(d),
        .enable(enable), .up(up), .Q(q1), .at_max(amax[1]), .at_min(amin[1]), .tc(tcs[1]));
    mod_up_down_counter #(.BITS(4), .MOD(10), .SATURATE(0), .PRESCALE(3)) dut2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .D(d),
        .enable(enable), .up(up), .Q(q2), .at_max(amax[2]), .at_min(amin[2]), .tc(tcs[2]));
    mod_up_down_counter #(.BITS(3), .MOD(5), .SATURATE(1), .PRESCALE(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .D(d[2:0]),
        .enable(enable), .up(up), .Q(q3), .at_max(amax[3]), .at_min(amin[3]), .tc(tcs[3]));

    function automatic void chk(input string nm, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: counts qualified enables, steps every CP of them.
    always @(posedge clk or negedge reset_n) begin
        int dv;
        int lim;
        for (int i = 0; i < 4; i++) begin
            if (!reset_n) begin
                mq[i] = 0; mp[i] = 0; mtc[i] = 0;
            end else begin
                dv = (i == 3) ? int'(d) % 8 : int'(d);
                lim = up ? CM[i] - 1 : 0;
                mtc[i] = 0;
                if (clear) begin
                    mq[i] = 0; mp[i] = 0;
                end else if (load) begin
                    mq[i] = (dv > CM[i] - 1) ? CM[i] - 1 : dv;
                    mp[i] = 0;
                end else if (enable) begin
                    mp[i] = mp[i] + 1;
                    if (mp[i] == CP[i]) begin
                        mp[i] = 0;
                        if (mq[i] == lim) begin
                            mtc[i] = 1;
                            if (CS[i] == 0) mq[i] = up ? 0 : CM[i] - 1;
                        end else begin
                            mq[i] = (mq[i] + (up ? 1 : CM[i] - 1)) % CM[i];
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        int aq[4];
        if (reset_n) begin
            aq[0] = int'(q0); aq[1] = int'(q1); aq[2] = int'(q2); aq[3] = int'(q3);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_q%0d", i), aq[i], mq[i]);
                chk($sformatf("model_tc%0d", i), int'(tcs[i]), mtc[i]);
                chk($sformatf("model_atmax%0d", i), int'(amax[i]), int'(mq[i] == CM[i] - 1));
                chk($sformatf("model_atmin%0d", i), int'(amin[i]), int'(mq[i] == 0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp5 [8] = '{0, 0, 1, 1, 1, 1, 1, 2};
        int en5  [8] = '{1, 1, 1, 1, 0, 0, 1, 1};

        tick();
        chk("reset_q", int'(q0), 0);
        chk("reset_atmin", int'(amin[0]), 1);
        chk("reset_atmax", int'(amax[0]), 0);
        chk("reset_tc", int'(tcs[0]), 0);
        tick();
        reset_n = 1'b1;

        // Count up through a wrap.
        enable = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("up_q", int'(q0), (i + 1) % 10);
            chk("up_tc", int'(tcs[0]), (i == 9) ? 1 : 0);
        end

        // Down-count wrap from zero.
        enable = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0; up = 1'b0; enable = 1'b1;
        tick();
        chk("down_wrap_q", int'(q0), 9);
        chk("down_wrap_tc", int'(tcs[0]), 1);
        chk("down_wrap_atmax", int'(amax[0]), 1);
        enable = 1'b0;
        tick();
        chk("tc_one_cycle", int'(tcs[0]), 0);

        // Saturation at max, then count down.
        load = 1'b1; d = 4'd9;
        tick();
        load = 1'b0;
        chk("sat_load_q", int'(q1), 9);
        up = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_hold_q", int'(q1), 9);
            chk("sat_hold_tc", int'(tcs[1]), 1);
        end
        up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_down_q", int'(q1), 8 - i);
            chk("sat_down_tc", int'(tcs[1]), 0);
        end
        enable = 1'b0;

        // Load clamping and priority.
        load = 1'b1; d = 4'd12;
        tick();
        chk("load_clamp", int'(q0), 9);
        chk("load_clamp3", int'(q3), 4);
        clear = 1'b1; d = 4'd7;
        tick();
        chk("clear_over_load", int'(q0), 0);
        clear = 1'b0; enable = 1'b1; up = 1'b1; d = 4'd4;
        tick();
        chk("load_over_count", int'(q0), 4);
        chk("load_over_count_tc", int'(tcs[0]), 0);
        load = 1'b0; enable = 1'b0;

        // Prescaler phase held across an enable gap.
        clear = 1'b1;
        tick();
        clear = 1'b0; up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enable = en5[i][0];
            tick();
            chk("prescale_q", int'(q2), exp5[i]);
        end
        enable = 1'b0;

        // Asynchronous reset between edges.
        load = 1'b1; d = 4'd5;
        tick();
        load = 1'b0;
        chk("pre_async_q", int'(q0), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_q", int'(q0), 0);
        chk("async_tc", int'(tcs[0]), 0);
        chk("async_atmin", int'(amin[0]), 1);
        tick();
        reset_n = 1'b1;

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            clear  = ($urandom_range(0, 49) == 0);
            load   = ($urandom_range(0, 19) == 0);
            d      = 4'($urandom_range(0, 15));
            enable = ($urandom_range(0, 9) < 8);
            up     = ($urandom_range(0, 3) != 0) ^ (i / 500 % 2 == 1);
            tick();
        end

        clear = 1'b0; load = 1'b0; enable = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
